// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with 3-sample majority vote, start-glitch
// rejection, framing/overrun flags and a valid/ready output handshake.
// Optional feature macro: UART_RX_PARITY_EN (adds one parity bit after the data bits).
module uart_rx_os #(
    parameter int unsigned CLK_HZ     = 27000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OSR        = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned DIV    = (CLK_HZ + BAUD * OSR / 2) / (BAUD * OSR);
    localparam int unsigned TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OS_W   = $clog2(OSR);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

    // Unsupported parameter sets never leave IDLE rather than misreceiving.
    localparam bit CFG_OK = (OSR % 2 == 0) && (OSR >= 8) && (DIV >= 1) &&
                            (DATA_BITS >= 5) && (DATA_BITS <= 9) &&
                            (STOP_BITS >= 1) && (STOP_BITS <= 2) && (PARITY_ODD <= 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t state, next_state;

    logic                 sync1, rxs, rxs_d;
    logic [TICK_W-1:0]    tick_cnt;
    logic [OS_W-1:0]      os_cnt;
    logic                 samp0, samp1;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 frame_pend;
`ifdef UART_RX_PARITY_EN
    logic                 parity_pend;
`endif

    logic os_tick_c, decide_c, wrap_c, vote_c, last_stop_c, load_c;

    assign os_tick_c   = (state != IDLE) && (tick_cnt == TICK_W'(DIV - 1));
    assign decide_c    = os_tick_c && (os_cnt == OS_W'(OSR / 2 + 1));
    assign wrap_c      = os_tick_c && (os_cnt == OS_W'(OSR - 1));
    assign vote_c      = (samp0 & samp1) | (samp0 & rxs) | (samp1 & rxs);
    assign last_stop_c = (stop_cnt == 1'(STOP_BITS - 1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Next-state decode and output-load strobe.
    always_comb begin
        next_state = state;
        load_c     = 1'b0;
        case (state)
            IDLE:   if (CFG_OK && rxs_d && !rxs) next_state = START;
            START: begin
                if (decide_c && vote_c) next_state = IDLE;
                else if (wrap_c)        next_state = DATA;
            end
            DATA: begin
                if (wrap_c && (bit_cnt == BIT_W'(DATA_BITS))) begin
`ifdef UART_RX_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (wrap_c) next_state = STOP;
`endif
            STOP: begin
                if (decide_c && last_stop_c) begin
                    load_c     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Synchroniser, baud/oversample counters, vote samples and frame assembly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1      <= 1'b1;
            rxs        <= 1'b1;
            rxs_d      <= 1'b1;
            tick_cnt   <= '0;
            os_cnt     <= '0;
            samp0      <= 1'b1;
            samp1      <= 1'b1;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            shift      <= '0;
            frame_pend <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_pend <= 1'b0;
`endif
        end else begin
            sync1 <= rx;
            rxs   <= sync1;
            rxs_d <= rxs;
            if (state == IDLE) begin
                tick_cnt   <= '0;
                os_cnt     <= '0;
                bit_cnt    <= '0;
                stop_cnt   <= 1'b0;
                frame_pend <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_pend <= 1'b0;
`endif
            end else begin
                tick_cnt <= os_tick_c ? '0 : tick_cnt + TICK_W'(1);
                if (os_tick_c)
                    os_cnt <= (os_cnt == OS_W'(OSR - 1)) ? '0 : os_cnt + OS_W'(1);
                if (os_tick_c && (os_cnt == OS_W'(OSR / 2 - 1))) samp0 <= rxs;
                if (os_tick_c && (os_cnt == OS_W'(OSR / 2)))     samp1 <= rxs;
                if (decide_c && (state == DATA)) begin
                    shift   <= {vote_c, shift[DATA_BITS-1:1]};
                    bit_cnt <= bit_cnt + BIT_W'(1);
                end
`ifdef UART_RX_PARITY_EN
                if (decide_c && (state == PARITY))
                    parity_pend <= vote_c ^ (^shift) ^ 1'(PARITY_ODD);
`endif
                if (decide_c && (state == STOP)) begin
                    if (!vote_c) frame_pend <= 1'b1;
                    stop_cnt <= stop_cnt + 1'b1;
                end
            end
        end
    end

    // Output holding registers and valid/ready handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            busy <= (next_state != IDLE);
            if (load_c) begin
                data      <= shift;
                frame_err <= frame_pend | ~vote_c;
`ifdef UART_RX_PARITY_EN
                parity_err <= parity_pend;
`else
                parity_err <= 1'b0;
`endif
                valid   <= 1'b1;
                overrun <= valid & ~ready;
            end else if (valid && ready) begin
                valid      <= 1'b0;
                overrun    <= 1'b0;
                frame_err  <= 1'b0;
                parity_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed, table-driven checks of the oversampling UART receiver.
module tb_uart_rx_os;

    localparam int CLK_HZ = 1843200;
    localparam int BAUD   = 9600;
    localparam int OSR    = 16;
    localparam int BIT    = CLK_HZ / BAUD;               // 192 clks per bit
    localparam int DIV_E  = (CLK_HZ + BAUD * OSR / 2) / (BAUD * OSR);  // 12
`ifdef UART_RX_PARITY_EN
    localparam int STOP_IDX = 10;
`else
    localparam int STOP_IDX = 9;
`endif
    // 2 sync clks + 1 to enter START, first os_tick DIV later, then stop-bit vote at os count OSR/2+1
    localparam int L_EXP = 3 + DIV_E + (OSR * STOP_IDX + OSR / 2 + 1) * DIV_E;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses;
    int seen_at;
    logic [7:0] cap;
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    always #5 clk = ~clk;

    uart_rx_os #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OSR(OSR),
        .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid), .ready(ready),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun), .busy(busy)
    );

    typedef struct {
        logic [7:0] d;
        logic       stop_v;
        int         per;
        logic       fe;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Drive one frame starting at the current negedge; leaves the line idle high.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int per);
        rx = 1'b0;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (per) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ par_flip;
        repeat (per) @(negedge clk);
`endif
        rx = stop_v;
        repeat (per) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic wait_valid(input string nm);
        for (int k = 0; k < 4 * BIT; k++) begin
            if (valid === 1'b1) break;
            @(negedge clk);
        end
        check(nm, 32'(valid), 32'd1);
    endtask

    task automatic handshake();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h55, 1'b1, BIT,     1'b0};
        vecs[1] = '{8'hA3, 1'b0, BIT,     1'b1};
        vecs[2] = '{8'h0F, 1'b1, BIT,     1'b0};
        vecs[3] = '{8'h00, 1'b1, BIT,     1'b0};
        vecs[4] = '{8'hFF, 1'b1, BIT,     1'b0};
        vecs[5] = '{8'h80, 1'b1, 186,     1'b0};
        vecs[6] = '{8'h01, 1'b1, 198,     1'b0};
        vecs[7] = '{8'hC5, 1'b1, 186,     1'b0};
        vecs[8] = '{8'h3A, 1'b1, 198,     1'b0};

        rst = 1'b0; rx = 1'b1; ready = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_data", 32'(data), 32'h0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // Table: receive with ready low, inspect held frame, then consume it.
        for (int i = 0; i < 9; i++) begin
            send_frame(vecs[i].d, vecs[i].stop_v, vecs[i].per);
            check($sformatf("vec%0d_busy_after_stop", i), 32'(busy), 32'd0);
            wait_valid($sformatf("vec%0d_valid", i));
            check($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].d));
            check($sformatf("vec%0d_frame_err", i), 32'(frame_err), 32'(vecs[i].fe));
            check($sformatf("vec%0d_parity_err", i), 32'(parity_err), 32'd0);
            check($sformatf("vec%0d_overrun", i), 32'(overrun), 32'd0);
            handshake();
            check($sformatf("vec%0d_valid_clr", i), 32'(valid), 32'd0);
            check($sformatf("vec%0d_fe_clr", i), 32'(frame_err), 32'd0);
            check($sformatf("vec%0d_data_hold", i), 32'(data), 32'(vecs[i].d));
            repeat (BIT / 4) @(negedge clk);
        end

        // ready held high: exactly one valid pulse, at the expected latency.
        ready = 1'b1;
        pulses = 0; seen_at = -1; cap = 8'h00;
        fork
            send_frame(8'h55, 1'b1, BIT);
            begin
                for (int k = 1; k <= (STOP_IDX + 2) * BIT; k++) begin
                    @(negedge clk);
                    if (valid === 1'b1) begin
                        pulses++;
                        if (seen_at < 0) begin seen_at = k; cap = data; end
                    end
                end
            end
        join
        ready = 1'b0;
        check("rdy1_pulses", 32'(pulses), 32'd1);
        check("rdy1_data", 32'(cap), 32'h55);
        check("rdy1_latency_ok", 32'((seen_at >= L_EXP - 1) && (seen_at <= L_EXP + 1)), 32'd1);
        check("rdy1_busy", 32'(busy), 32'd0);

        // Start glitch shorter than half a bit must abort silently.
        rx = 1'b0;
        repeat (30) @(negedge clk);
        check("glitch_busy_start", 32'(busy), 32'd1);
        repeat (30) @(negedge clk);
        rx = 1'b1;
        pulses = 0;
        for (int k = 0; k < 3 * BIT; k++) begin
            @(negedge clk);
            if (valid === 1'b1) pulses++;
        end
        check("glitch_no_valid", 32'(pulses), 32'd0);
        check("glitch_busy_end", 32'(busy), 32'd0);

        // Back-to-back frames with ready low: second overwrites first.
        send_frame(8'h11, 1'b1, BIT);
        check("ovr_first_overrun", 32'(overrun), 32'd0);
        send_frame(8'h22, 1'b1, BIT);
        wait_valid("ovr_valid");
        check("ovr_data", 32'(data), 32'h22);
        check("ovr_overrun", 32'(overrun), 32'd1);
        handshake();
        check("ovr_valid_clr", 32'(valid), 32'd0);
        check("ovr_overrun_clr", 32'(overrun), 32'd0);
        repeat (BIT / 4) @(negedge clk);

        // Load and handshake on the same edge: no overrun, valid stays high.
        send_frame(8'h11, 1'b1, BIT);
        wait_valid("same_first_valid");
        repeat (BIT / 4) @(negedge clk);
        fork
            send_frame(8'h22, 1'b1, BIT);
            begin
                repeat (L_EXP - 1) @(negedge clk);
                ready = 1'b1;
                @(negedge clk);
                ready = 1'b0;
                check("same_valid", 32'(valid), 32'd1);
                check("same_data", 32'(data), 32'h22);
                check("same_overrun", 32'(overrun), 32'd0);
                @(negedge clk);
                check("same_valid_held", 32'(valid), 32'd1);
            end
        join
        handshake();
        check("same_valid_clr", 32'(valid), 32'd0);
        repeat (BIT / 4) @(negedge clk);

        // Reset after 4 data bits drops the frame.
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (i % 2 == 0);
            repeat (BIT) @(negedge clk);
        end
        rst = 1'b0; rx = 1'b1;
        repeat (4) @(negedge clk);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_data", 32'(data), 32'h0);
        rst = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("mrst_no_valid", 32'(valid), 32'd0);
        send_frame(8'h3C, 1'b1, BIT);
        wait_valid("mrst_valid");
        check("mrst_data_new", 32'(data), 32'h3C);
        check("mrst_fe", 32'(frame_err), 32'd0);
        handshake();
        repeat (BIT / 4) @(negedge clk);

        // Break: one all-zero frame with frame error, then no retrigger while low.
        rx = 1'b0;
        repeat (20 * BIT) @(negedge clk);
        check("brk_valid", 32'(valid), 32'd1);
        check("brk_data", 32'(data), 32'h00);
        check("brk_fe", 32'(frame_err), 32'd1);
        check("brk_busy", 32'(busy), 32'd0);
        handshake();
        repeat (5 * BIT) @(negedge clk);
        check("brk_no_retrigger", 32'(valid), 32'd0);
        check("brk_idle", 32'(busy), 32'd0);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("brk_release_valid", 32'(valid), 32'd0);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 needs parity bit 1.
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1, BIT);
        wait_valid("par_bad_valid");
        check("par_bad_data", 32'(data), 32'h07);
        check("par_bad_err", 32'(parity_err), 32'd1);
        handshake();
        check("par_err_clr", 32'(parity_err), 32'd0);
        repeat (BIT / 4) @(negedge clk);
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1, BIT);
        wait_valid("par_ok_valid");
        check("par_ok_err", 32'(parity_err), 32'd0);
        handshake();
`endif

        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
